// File: rtl/alu_op_queue.sv
// alu_op_queue: show-ahead command FIFO in front of the ALU.
// Commands arrive on a valid/ready handshake and illegal opcodes are filtered out.
// The head command is presented to the ALU on a second valid/ready handshake.
// Occupancy and illegal-opcode status are kept for the monitor and scoreboard.
// Optional feature macro: ALU_OPQ_BYPASS_EN. When it is defined, a legal command
// arriving at an empty queue passes straight through to the ALU in the same cycle.
module alu_op_queue #(
   parameter int unsigned DATASIZE = 8,
   parameter int unsigned OPSIZE   = 4,
   parameter int unsigned NUM_OPS  = 12,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATASIZE-1:0]       in_a,
   input  logic [DATASIZE-1:0]       in_b,
   input  logic [OPSIZE-1:0]         in_op,
   output logic                      alu_valid,
   input  logic                      alu_ready,
   output logic [DATASIZE-1:0]       alu_a,
   output logic [DATASIZE-1:0]       alu_b,
   output logic [OPSIZE-1:0]         alu_op,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty,
   output logic                      err_illegal,
   output logic [7:0]                illegal_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATASIZE-1:0] mem_a  [DEPTH];
   logic [DATASIZE-1:0] mem_b  [DEPTH];
   logic [OPSIZE-1:0]   mem_op [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             err_q;
   logic [7:0]       illegal_cnt_q;

   logic in_legal, push_acc, push_legal, push_illegal;
   logic byp_valid, byp_take, wr_en, rd_en;

   // Handshake qualification; all of it is derived from registered state plus the inputs.
   always_comb begin
      in_legal     = 32'(in_op) < NUM_OPS;
      empty        = (count_q == '0);
      full         = (count_q == CNT_W'(DEPTH));
      in_ready     = !full;
      push_acc     = in_valid && in_ready;
      push_legal   = push_acc && in_legal;
      push_illegal = push_acc && !in_legal;
`ifdef ALU_OPQ_BYPASS_EN
      byp_valid    = empty && in_valid && in_legal;
`else
      byp_valid    = 1'b0;
`endif
      byp_take     = byp_valid && alu_ready;
      wr_en        = push_legal && !byp_take && !flush;
      rd_en        = !empty && alu_ready;
   end

   // Head presentation: show-ahead from storage, zeros while empty, or the bypassed input.
   always_comb begin
      alu_valid = !empty || byp_valid;
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = '0;
      if (!empty) begin
         alu_a  = mem_a[rd_ptr_q];
         alu_b  = mem_b[rd_ptr_q];
         alu_op = mem_op[rd_ptr_q];
      end else if (byp_valid) begin
         alu_a  = in_a;
         alu_b  = in_b;
         alu_op = in_op;
      end
   end

   // Command storage; write only, so it needs no reset (reads are gated by empty).
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_a[wr_ptr_q]  <= in_a;
         mem_b[wr_ptr_q]  <= in_b;
         mem_op[wr_ptr_q] <= in_op;
      end
   end

   // Pointers and occupancy; flush wins over any push or pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   // Illegal-opcode pulse and saturating counter; a push dropped by flush is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q         <= 1'b0;
         illegal_cnt_q <= '0;
      end else begin
         err_q <= push_illegal && !flush;
         if (push_illegal && !flush && illegal_cnt_q != 8'hFF)
            illegal_cnt_q <= illegal_cnt_q + 8'd1;
      end
   end

   assign count       = count_q;
   assign err_illegal = err_q;
   assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_op_queue.sv
// Directed self-checking bench for alu_op_queue (default 8/4/12/4 configuration).
module tb_alu_op_queue;

   logic       clk = 1'b0;
   logic       rst_n, flush, in_valid, alu_ready;
   logic       in_ready, alu_valid, full, empty, err_illegal;
   logic [7:0] in_a, in_b, alu_a, alu_b, illegal_cnt;
   logic [3:0] in_op, alu_op;
   logic [2:0] count;

   int n_cmp = 0;
   int n_err = 0;

   alu_op_queue dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .count(count), .full(full), .empty(empty),
      .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      in_valid = v; in_a = a; in_b = b; in_op = op;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; alu_ready = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      #2;
      // reset state
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_alu_valid", 32'(alu_valid), 0);
      check("rst_count", 32'(count), 0);
      check("rst_illegal_cnt", 32'(illegal_cnt), 0);
      check("rst_err", 32'(err_illegal), 0);
      check("rst_alu_a", 32'(alu_a), 0);
      #10 rst_n = 1'b1;
      step();

      // single push, one-cycle latency, then popped
      alu_ready = 1'b1;
      drive(1'b1, 8'h12, 8'h34, 4'd2);
      check("lat_no_same_cycle", 32'(alu_valid), 0);
      step();
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      check("lat_valid", 32'(alu_valid), 1);
      check("lat_a", 32'(alu_a), 32'h12);
      check("lat_b", 32'(alu_b), 32'h34);
      check("lat_op", 32'(alu_op), 2);
      check("lat_count", 32'(count), 1);
      step();
      check("lat_empty", 32'(empty), 1);
      check("lat_count0", 32'(count), 0);

      // fill to full with the ALU stalled
      alu_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(8'h10 + i), 8'(8'h20 + i), 4'(i));
         step();
      end
      check("full_flag", 32'(full), 1);
      check("full_in_ready", 32'(in_ready), 0);
      check("full_count", 32'(count), 4);
      drive(1'b1, 8'hEE, 8'hEE, 4'd5);
      step();
      check("full_5th_count", 32'(count), 4);
      check("full_stall_op", 32'(alu_op), 0);
      check("full_stall_a", 32'(alu_a), 32'h10);
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      alu_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_op", 32'(alu_op), 32'(i));
         check("drain_b", 32'(alu_b), 32'(8'h20 + i));
         step();
      end
      check("drain_empty", 32'(empty), 1);
      check("drain_valid", 32'(alu_valid), 0);

      // steady push+pop with three held; pointers wrap
      alu_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'h40 + i), 8'(8'h80 + i), 4'(i));
         step();
      end
      alu_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 8'(8'h43 + k), 8'(8'h83 + k), 4'((3 + k) % 12));
         check("ilv_a", 32'(alu_a), 32'(8'h40 + k));
         check("ilv_op", 32'(alu_op), 32'(k % 12));
         step();
         check("ilv_count", 32'(count), 3);
      end
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      for (int k = 10; k < 13; k++) begin
         check("ilv_tail_a", 32'(alu_a), 32'(8'h40 + k));
         step();
      end
      check("ilv_empty", 32'(empty), 1);

      // single illegal opcode
      alu_ready = 1'b0;
      drive(1'b1, 8'h55, 8'h66, 4'hF);
      check("ill_in_ready", 32'(in_ready), 1);
      step();
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      check("ill_err", 32'(err_illegal), 1);
      check("ill_cnt", 32'(illegal_cnt), 1);
      check("ill_count", 32'(count), 0);
      check("ill_alu_valid", 32'(alu_valid), 0);
      step();
      check("ill_err_pulse", 32'(err_illegal), 0);

      // flush with three queued and an illegal push in the same cycle
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'h70 + i), 8'h00, 4'(i));
         step();
      end
      check("pre_flush_count", 32'(count), 3);
      flush = 1'b1;
      drive(1'b1, 8'h99, 8'h99, 4'hC);
      step();
      flush = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      check("flush_count", 32'(count), 0);
      check("flush_empty", 32'(empty), 1);
      check("flush_valid", 32'(alu_valid), 0);
      check("flush_ill_cnt", 32'(illegal_cnt), 1);
      check("flush_err", 32'(err_illegal), 0);
      // after flush the queue restarts from a clean pointer state
      drive(1'b1, 8'hA5, 8'h5A, 4'd7);
      step();
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      check("post_flush_a", 32'(alu_a), 32'hA5);
      check("post_flush_count", 32'(count), 1);
      alu_ready = 1'b1;
      step();
      alu_ready = 1'b0;

      // illegal counter saturates
      drive(1'b1, 8'h00, 8'h00, 4'hF);
      for (int i = 0; i < 299; i++) step();
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      check("sat_cnt", 32'(illegal_cnt), 255);
      check("sat_count", 32'(count), 0);
      step();
      check("sat_hold", 32'(illegal_cnt), 255);

      // asynchronous reset with two queued
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 8'(8'h30 + i), 8'h00, 4'(i + 1));
         step();
      end
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      check("pre_arst_count", 32'(count), 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", 32'(count), 0);
      check("arst_empty", 32'(empty), 1);
      check("arst_valid", 32'(alu_valid), 0);
      check("arst_alu_a", 32'(alu_a), 0);
      check("arst_ill_cnt", 32'(illegal_cnt), 0);
      #3 rst_n = 1'b1;
      step();
      check("arst_stays_empty", 32'(empty), 1);

`ifdef ALU_OPQ_BYPASS_EN
      // combinational bypass on an empty queue
      alu_ready = 1'b1;
      drive(1'b1, 8'h77, 8'h88, 4'd1);
      #1;
      check("byp_valid", 32'(alu_valid), 1);
      check("byp_a", 32'(alu_a), 32'h77);
      check("byp_op", 32'(alu_op), 1);
      step();
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      check("byp_count", 32'(count), 0);
      check("byp_empty", 32'(empty), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_op_queue.md
Name: alu_op_queue

Overview:
- Command buffer directly upstream of the ALU.
- Accepts operand/opcode commands from the stimulus/issue side over a valid/ready handshake and holds them in a small show-ahead FIFO.
- Presents the head command to the ALU over a second valid/ready handshake.
- Filters illegal opcodes and keeps occupancy/error status for the monitor and scoreboard.

Parameters:
- DATASIZE, 8, operand width in bits.
- OPSIZE, 4, opcode width in bits.
- NUM_OPS, 12, number of legal opcodes; any in_op >= NUM_OPS is illegal.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all queued commands.
- in_valid  input  1  upstream command valid.
- in_ready  output  1  queue can accept a command this cycle.
- in_a  input  DATASIZE  operand A.
- in_b  input  DATASIZE  operand B.
- in_op  input  OPSIZE  opcode.
- alu_valid  output  1  head command valid toward ALU.
- alu_ready  input  1  ALU accepts head command.
- alu_a  output  DATASIZE  head operand A.
- alu_b  output  DATASIZE  head operand B.
- alu_op  output  OPSIZE  head opcode.
- count  output  $clog2(DEPTH)+1  entries held.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- err_illegal  output  1  one-cycle pulse when an illegal command is accepted.
- illegal_cnt  output  8  saturating count of illegal commands.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, count and illegal_cnt clear to 0; err_illegal = 0.
  - empty = 1, full = 0, in_ready = 1, alu_valid = 0.
  - alu_a, alu_b and alu_op drive 0 while empty.
  - Reset mid-transfer discards all contents; no partial command survives.
- Push (in_valid && in_ready):
  - in_ready = !full, combinational from registered state; it never depends on alu_ready.
  - A legal command is written at the write pointer; count increments next edge.
  - An illegal command (in_op >= NUM_OPS) is accepted but not stored. err_illegal pulses high for the following cycle and illegal_cnt increments, saturating at 255. count is unchanged.
- Pop (alu_valid && alu_ready):
  - alu_valid = !empty.
  - alu_a/b/op show the head entry combinationally from storage.
  - The read pointer advances on the edge.
- Latency: a legal push to an empty queue gives alu_valid = 1 on the next cycle, with the pushed data.
- Simultaneous push and pop, non-full and non-empty: both occur and count is unchanged.
- Full: in_ready = 0, so no push; a pop in that cycle frees a slot that is visible the next cycle.
- Empty: alu_valid = 0, so no pop occurs regardless of alu_ready.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- Order: strict FIFO; the ALU sees legal commands in acceptance order.
- flush:
  - Next edge sets pointers and count to 0.
  - A push in the flush cycle is dropped, including its illegal-opcode accounting.
  - A pop in the flush cycle is still considered complete.
  - illegal_cnt is not cleared by flush.
- alu_a/b/op must stay stable while alu_valid && !alu_ready.

Optional Feature:
- Macro: ALU_OPQ_BYPASS_EN.
- When defined:
  - If the queue is empty and in_valid carries a legal opcode, the input passes combinationally: alu_valid = 1 and alu_a/b/op = in_a/b/op in the same cycle.
  - If alu_ready is also 1, the command is consumed and not written; count stays 0.
  - Otherwise it is written normally.
- When undefined: minimum latency is 1 cycle, and the ALU-side outputs depend only on registered state.

Test Plan:
- Reset then push (a=8'h12, b=8'h34, op=2) with alu_ready=1 -> next cycle alu_valid=1 with 12/34/2; one cycle later empty=1, count=0.
- Hold alu_ready=0 and push 4 legal commands (op 0..3) -> full=1, in_ready=0, count=4. A 5th in_valid is not accepted. Then alu_ready=1 -> ops 0,1,2,3 emerge in order.
- Interleave: fill 3, then drive push and pop every cycle for 10 cycles -> count stays 3. Pointers wrap; output order matches the input sequence.
- Push op=4'hF (>= NUM_OPS) -> accepted (in_ready=1), err_illegal high for one cycle, illegal_cnt=1, count unchanged. Repeat 300 times -> illegal_cnt=255.
- With 3 queued, assert flush together with a push -> next cycle count=0, empty=1, alu_valid=0; illegal_cnt is preserved.
- Assert rst_n=0 asynchronously between edges with 2 queued -> outputs take reset values immediately. With ALU_OPQ_BYPASS_EN: empty queue, push op=1 with alu_ready=1 -> alu_valid=1 in the same cycle and count stays 0.
